wildcat_boot_loader: RTL and testbench

WILDCAT_BOOT_LOADER -- requirements
Module: wildcat_boot_loader

---
 rtl/wildcat_boot_pkg.sv | 22 ++
 rtl/wildcat_uart_rx.sv | 105 ++++++++++
 rtl/wildcat_boot_loader.sv | 135 +++++++++++++
 tb/tb_wildcat_boot_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/wildcat_boot_pkg.sv
// Shared definitions for the Wildcat boot loader.
// Contents: receive FSM state enum, frame length, timeout multiplier and
// default clock cycles per UART bit.
package wildcat_boot_pkg;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

    // Bytes per boot frame: 4 address bytes then 4 data bytes.
    localparam int unsigned FrameLen = 8;

    // Partial-frame timeout, in bit periods.
    localparam int unsigned TimeoutMult = 20;

    // 50 MHz / 115200 baud.
    localparam int unsigned DefaultClksPerBit = 434;

endpackage

// File: rtl/wildcat_uart_rx.sv
// UART 8N1 byte receiver for the Wildcat boot loader.
// Ports:
//   clock     - system clock, rising edge
//   reset     - synchronous active-high reset
//   rx        - asynchronous serial input, idles high
//   rx_byte   - last received byte (valid when rx_valid is high)
//   rx_valid  - one-cycle strobe: stop bit sampled high, byte accepted
//   frame_err - one-cycle strobe: stop bit sampled low, byte discarded
// rx_valid and frame_err are asserted during the cycle the stop bit is
// sampled, so a registering consumer reacts on the following cycle.
module wildcat_uart_rx
    import wildcat_boot_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);

    logic        rx_meta_q;
    logic        rx_sync_q;
    logic        rx_prev_q;
    rx_state_e   state_q, state_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RxIdle;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            // Delayed copy of the synchronised line for falling-edge detection,
            // so a line held low after a bad stop bit does not retrigger.
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + 16'd1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rx_valid  = 1'b0;
        frame_err = 1'b0;

        unique case (state_q)
            RxIdle: begin
                clk_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d   = RxStart;
                    bit_cnt_d = '0;
                end
            end
            RxStart: begin
                // Mid-point of the start bit: a high line here is a glitch.
                if (clk_cnt_q == HalfLast) begin
                    clk_cnt_d = '0;
                    state_d   = rx_sync_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RxStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            RxStop: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d = '0;
                    state_d   = RxIdle;
                    rx_valid  = rx_sync_q;
                    frame_err = !rx_sync_q;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    assign rx_byte = shift_q;

endmodule

// File: rtl/wildcat_boot_loader.sv
// Wildcat boot loader: receives 8-byte frames over UART and writes them into
// instruction memory, then releases the core from reset.
// Frame: bytes 0-3 little-endian address, bytes 4-7 little-endian data.
// Address bit 31 clear -> one memory write; set -> core released (run state),
// after which further bytes are ignored.
// Ports:
//   clock, reset - system clock and synchronous active-high reset
//   rx           - UART 8N1 serial input
//   wr_en        - one-cycle instruction-memory write strobe
//   wr_addr      - write byte address, held until the next write
//   wr_data      - write word, held until the next write
//   cpu_reset    - high holds the core in reset; drops once for good
//   frame_err    - one-cycle pulse on a bad stop bit
// Build option: define BOOT_TIMEOUT_EN to drop a partial frame after
// TimeoutMult*CLKS_PER_BIT cycles without an accepted byte.
module wildcat_boot_loader
    import wildcat_boot_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_reset,
    output logic        frame_err
);

    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ferr;

    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [55:0] buf_q, buf_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        frame_err_q;
    logic        byte_take;
    logic        timeout_hit;

    wildcat_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clock    (clock),
        .reset    (reset),
        .rx       (rx),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .frame_err(rx_ferr)
    );

    // Bytes only count while the core is still held in reset.
    assign byte_take = rx_valid && cpu_reset_q;

`ifdef BOOT_TIMEOUT_EN
    localparam logic [31:0] TimeoutLast = 32'(TimeoutMult * CLKS_PER_BIT - 1);

    logic [31:0] idle_cnt_q;

    always_ff @(posedge clock) begin
        if (reset || byte_take || (byte_cnt_q == 3'd0)) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 32'd1;
        end
    end

    assign timeout_hit = (byte_cnt_q != 3'd0) && (idle_cnt_q == TimeoutLast);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt_q  <= '0;
            buf_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_reset_q <= 1'b1;
            frame_err_q <= 1'b0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            buf_q       <= buf_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cpu_reset_q <= cpu_reset_d;
            frame_err_q <= rx_ferr;
        end
    end

    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        buf_d       = buf_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        cpu_reset_d = cpu_reset_q;

        if (byte_take) begin
            if (byte_cnt_q == 3'(FrameLen - 1)) begin
                // Last byte goes straight to the output; only 7 are buffered.
                byte_cnt_d = '0;
                if (buf_q[31]) begin
                    cpu_reset_d = 1'b0;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = buf_q[31:0];
                    wr_data_d = {rx_byte, buf_q[55:32]};
                end
            end else begin
                byte_cnt_d = byte_cnt_q + 3'd1;
                for (int i = 0; i < 7; i++) begin
                    if (byte_cnt_q == 3'(i)) begin
                        buf_d[i*8 +: 8] = rx_byte;
                    end
                end
            end
        end else if (timeout_hit) begin
            byte_cnt_d = '0;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cpu_reset = cpu_reset_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_wildcat_boot_loader.sv
// Self-checking bench for wildcat_boot_loader (CLKS_PER_BIT = 16).
// A byte-level reference model queues expected writes; a monitor pops them
// whenever the DUT strobes wr_en.
module tb_wildcat_boot_loader;

    localparam int unsigned CPB = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx    = 1'b1;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_reset;
    logic        frame_err;

    wildcat_boot_loader #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rx       (rx),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_reset(cpu_reset),
        .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  model_frame[$];
    bit          model_run   = 1'b0;
    int          exp_ferr    = 0;
    int          obs_ferr    = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %0h, required %0h", name, act, req);
        end
    endfunction

    // Reference model: a frame is just the next 8 good bytes while not running.
    function automatic void model_byte(logic [7:0] b, bit ok);
        logic [31:0] addr;
        logic [31:0] data;
        if (!ok) begin
            exp_ferr++;
        end else if (!model_run) begin
            model_frame.push_back(b);
            if (model_frame.size() == 8) begin
                addr = {model_frame[3], model_frame[2], model_frame[1], model_frame[0]};
                data = {model_frame[7], model_frame[6], model_frame[5], model_frame[4]};
                if (addr[31]) model_run = 1'b1;
                else exp_q.push_back({addr, data});
                model_frame.delete();
            end
        end
    endfunction

    // Monitor / scoreboard.
    initial begin
        logic [63:0] e;
        bit          prev_wr_en;
        prev_wr_en = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_wr_en = 1'b0;
            end else begin
                if (frame_err) obs_ferr++;
                if (wr_en) begin
                    check("wr_en_width", 64'(prev_wr_en), 64'd0);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_write: actual addr %0h data %0h, required none",
                                 wr_addr, wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 64'(wr_addr), 64'(e[63:32]));
                        check("wr_data", 64'(wr_data), 64'(e[31:0]));
                    end
                end
                prev_wr_en = wr_en;
            end
        end
    end

    initial begin
        #(900_000);
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input bit ok, input int gap);
        model_byte(b, ok);
        @(negedge clock);
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx = ok;
        repeat (CPB) @(negedge clock);
        rx = 1'b1;
        repeat (gap + 2) @(negedge clock);
    endtask

    task automatic send_frame(input logic [31:0] addr, input logic [31:0] data);
        for (int i = 0; i < 4; i++) send_byte(addr[i*8 +: 8], 1'b1, 0);
        for (int i = 0; i < 4; i++) send_byte(data[i*8 +: 8], 1'b1, 0);
    endtask

    task automatic drain(input string name);
        repeat (40) @(negedge clock);
        check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        check({name, "_ferr"}, 64'(obs_ferr), 64'(exp_ferr));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        exp_q.delete();
        model_frame.delete();
        model_run = 1'b0;
        reset = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;

        do_reset();

        // Basic write.
        send_frame(32'h0000_0000, 32'h0010_0513);
        drain("basic");
        check("basic_addr_held", 64'(wr_addr), 64'h0);
        check("basic_data_held", 64'(wr_data), 64'h0010_0513);
        check("basic_cpu_reset", 64'(cpu_reset), 64'd1);

        // Bad stop bit does not advance the byte count.
        send_byte(8'($urandom), 1'b0, 4);
        check("ferr_seen", 64'(obs_ferr), 64'(exp_ferr));
        send_frame(32'h0000_0040, 32'h1234_5678);
        drain("ferr_frame");

        // Short low glitch: no byte, no error.
        @(negedge clock);
        rx = 1'b0;
        repeat (4) @(negedge clock);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        check("glitch_ferr", 64'(obs_ferr), 64'(exp_ferr));
        send_frame(32'h0000_0080, 32'hA5A5_0F0F);
        drain("glitch_frame");

        // Reset mid-frame discards partial bytes.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, 0);
        do_reset();
        send_frame(32'h0000_00C0, 32'h0BAD_F00D);
        drain("midreset");

        // Long idle after a partial frame.
        send_byte(8'hAA, 1'b1, 0);
        send_byte(8'hBB, 1'b1, 0);
        send_byte(8'hCC, 1'b1, 0);
        repeat (400) @(negedge clock);
`ifdef BOOT_TIMEOUT_EN
        model_frame.delete();
`endif
        send_frame(32'h0000_0100, 32'hCAFE_F00D);
        drain("timeout");
        do_reset();

        // Randomised frames with interleaved bad bytes and random gaps.
        for (int f = 0; f < 12; f++) begin
            a = $urandom & 32'h7FFF_FFFC;
            d = $urandom;
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    send_byte(8'($urandom), 1'b0, $urandom_range(0, 40));
                end
                send_byte((i < 4) ? a[i*8 +: 8] : d[(i-4)*8 +: 8], 1'b1,
                          $urandom_range(0, 40));
            end
        end
        drain("random");

        // Write, then release the core, then ignored traffic.
        send_frame(32'h0000_0004, 32'hDEAD_BEEF);
        drain("pre_run");
        check("pre_run_addr", 64'(wr_addr), 64'h4);
        check("pre_run_data", 64'(wr_data), 64'hDEAD_BEEF);
        send_frame(32'h8000_0000, 32'h0000_0000);
        drain("run");
        check("run_cpu_reset", 64'(cpu_reset), 64'd0);
        send_frame(32'h0000_0008, 32'h4433_2211);
        send_byte(8'h5A, 1'b0, 4);
        drain("ignored");
        check("ignored_cpu_reset", 64'(cpu_reset), 64'd0);
        check("ignored_addr", 64'(wr_addr), 64'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
